display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS common-anode digits.
//  Sequences digit index and slot timing, and drives the decoder's BCD input.
//  Registers the returned segments and drives active-low digit enables.
//  Accepts new display values via a valid/ready handshake; they are applied only at frame boundaries (no tearing).
//  Sits between the value source (counter/FSM logic) and the board HEX pins; the decoder stays a separate instance.
// PARAMETERS
//  NUM_DIGITS    4       digits scanned per frame (>=2)
//  PRESCALE      50000   clock cycles per digit slot (> BLANK_CYCLES)
//  BLANK_CYCLES  2       anti-ghost blank cycles at start of each slot (>=1)
// PORTS
//  CLOCK_50     in   1             system clock, all logic rising-edge
//  RST_N        in   1             asynchronous active-low reset
//  value_in     in   4*NUM_DIGITS  BCD digits, [3:0] = digit 0 (least significant)
//  load_valid   in   1             value_in offered
//  load_ready   out  1             pending buffer empty; transfer when valid&&ready
//  blank_lz     in   1             1 = suppress leading zeros (digit 0 never suppressed)
//  bcd_out      out  4             to shared decoder input
//  seg_in       in   7             from shared decoder, active-low segments
//  seg_out      out  7             registered segments to HEX pins, active-low
//  digit_en_n   out  NUM_DIGITS    active-low digit enables, at most one low
//  frame_done   out  1             1-cycle pulse at frame wrap
//  bad_digit    out  1             sticky: an active digit > 9 was scanned
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): state=BLANK, idx=0, slot_cnt=0, active=0, pending empty;
//   bcd_out=0, seg_out=7'h7F, digit_en_n=all 1, load_ready=1, frame_done=0, bad_digit=0.
//  FSM per slot:
//   BLANK: BLANK_CYCLES cycles, all enables high, bcd_out=active[idx].
//   SHOW: PRESCALE-BLANK_CYCLES cycles, digit_en_n[idx]=0.
//   Transition SHOW->BLANK on slot_cnt==PRESCALE-1; slot_cnt then clears and idx increments.
//  seg_out <= seg_in every cycle (1-cycle latency). BLANK_CYCLES>=1 guarantees seg_out is valid before enable.
//  Wrap at idx==NUM_DIGITS-1 end of slot: idx->0, frame_done=1 for that cycle, active<=pending if pending full,
//   pending cleared, load_ready=1 next cycle.
//  Handshake: accept when load_valid&&load_ready -> pending<=value_in, load_ready=0 next cycle.
//   load_valid ignored while load_ready=0 (holder need not retain data after acceptance).
//  Simultaneous accept and wrap with pending empty: value_in bypasses to active at this wrap.
//  Leading-zero: with blank_lz=1, digit i>0 stays disabled in SHOW if active digits i..NUM_DIGITS-1 are all 0.
//   Timing unchanged; evaluated on active, not pending.
//  Digit >9 in active: enable held high for that slot (blanked), bad_digit set; cleared only by reset.
//  slot_cnt width = $clog2(PRESCALE); idx width = $clog2(NUM_DIGITS); idx never exceeds NUM_DIGITS-1.
// STRUCTURE
//  display_pkg: typedef enum {ST_BLANK, ST_SHOW} scan_state_t; SEG_BLANK=7'h7F; BCD_MAX=4'd9.
//  Sub-module slot_timer (PRESCALE, BLANK_CYCLES): slot_cnt, blank_end and slot_end strobes.
//  Top holds FSM, idx, active/pending buffers, LZ mask, output registers.
// TESTING  (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, decoder instanced in bench)
//  Reset then idle -> seg_out=7F, digit_en_n=1111.
//   First SHOW of digit0 at cycle 2 after reset release; frame_done every 32 cycles.
//  Load 16'h1234 mid-frame -> load_ready low until wrap.
//   Next frame: digit0 shows seg for 4, digit3 shows seg for 1; a second load while ready=0 is ignored.
//  Load accepted on the exact wrap cycle with pending empty -> new value displayed in the frame starting that cycle.
//  blank_lz=1, value 16'h0050 -> digits 3,2 never enabled; digits 1,0 show 5,0.
//   Value 16'h0000 -> only digit0 shows 0.
//  Value 16'h00A3 -> digit1 slot fully blanked, bad_digit=1 and stays 1 after value 16'h0003 loads.
//  Assert RST_N low mid-SHOW -> same cycle digit_en_n=1111, seg_out=7F; pending discarded, load_ready=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

    // Per-slot phase: BLANK hides all digits while the decoder settles, SHOW lights one digit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-low segments: all ones means every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Largest legal BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when a nibble is a displayable BCD digit.
    function automatic logic bcd_is_valid(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_slot_timer.sv
// Free-running slot counter: one slot is PRESCALE cycles, the first BLANK_CYCLES of which are blank.
module slot_timer #(
    parameter  int PRESCALE     = 50000,
    parameter  int BLANK_CYCLES = 2,
    localparam int CW           = $clog2(PRESCALE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic [CW-1:0] slot_cnt_o,
    output logic          blank_end_o,
    output logic          slot_end_o
);

    localparam logic [CW-1:0] CNT_LAST      = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] slot_cnt_q;
    logic [CW-1:0] slot_cnt_d;

    // Next count: wrap to zero on the last cycle of the slot.
    always_comb begin
        slot_cnt_d = slot_cnt_q + CW'(1);
        if (slot_cnt_q == CNT_LAST) begin
            slot_cnt_d = '0;
        end
    end

    // Counter register, cleared asynchronously so a reset restarts the slot at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign slot_cnt_o  = slot_cnt_q;
    assign blank_end_o = (slot_cnt_q == CNT_BLANK_END);
    assign slot_end_o  = (slot_cnt_q == CNT_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexes one external BCD-to-7-segment decoder across NUM_DIGITS common-anode digits.
// New values are double-buffered and only take effect at a frame boundary, so a frame never tears.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int PRESCALE     = 50000,
    parameter  int BLANK_CYCLES = 2,
    localparam int IW           = $clog2(NUM_DIGITS),
    localparam int CW           = $clog2(PRESCALE)
) (
    input  logic                    CLOCK_50,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    blank_lz,
    output logic [3:0]              bcd_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_done,
    output logic                    bad_digit,
    output scan_state_t             dbg_state_o,
    output logic [IW-1:0]           dbg_idx_o,
    output logic [CW-1:0]           dbg_slot_cnt_o
);

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    scan_state_t                 state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]  active_q, active_d;
    logic [NUM_DIGITS-1:0][3:0]  pending_q, pending_d;
    logic                        pend_full_q, pend_full_d;
    logic [6:0]                  seg_q;
    logic                        bad_q, bad_d;

    logic                        blank_end;
    logic                        slot_end;
    logic [CW-1:0]               slot_cnt;
    logic                        wrap;
    logic                        accept;
    logic [3:0]                  cur_digit;
    logic [NUM_DIGITS-1:0]       lz_mask;
    logic                        nz_above;

    slot_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk_i       (CLOCK_50),
        .rst_ni      (RST_N),
        .slot_cnt_o  (slot_cnt),
        .blank_end_o (blank_end),
        .slot_end_o  (slot_end)
    );

    // Handshake: a value transfers on any rising edge where load_valid && load_ready.
    // load_ready is simply "pending buffer empty"; it drops the cycle after a transfer and
    // rises again the cycle after the next frame wrap. load_valid is ignored while not ready.
    assign load_ready = ~pend_full_q;
    assign accept     = load_valid & ~pend_full_q;
    assign wrap       = slot_end & (idx_q == IDX_LAST);
    assign cur_digit  = active_q[idx_q];

    // Leading-zero mask: digit i>0 is suppressed when it and every digit above it are zero.
    always_comb begin
        lz_mask  = '0;
        nz_above = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            nz_above   = nz_above | (active_q[i] != 4'd0);
            lz_mask[i] = blank_lz & ~nz_above;
        end
    end

    // Scan FSM next state and digit enables; an illegal digit or a suppressed zero stays dark.
    always_comb begin
        state_d    = state_q;
        digit_en_n = '1;
        frame_done = wrap;
        unique case (state_q)
            ST_BLANK: begin
                if (blank_end) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (!lz_mask[idx_q] && bcd_is_valid(cur_digit)) begin
                    digit_en_n[idx_q] = 1'b0;
                end
                if (slot_end) begin
                    state_d = ST_BLANK;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Digit index advances at each slot end and returns to zero at the frame wrap.
    always_comb begin
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end
    end

    // Buffers: pending takes accepted values; at the wrap, pending (or a same-cycle accept) becomes active.
    always_comb begin
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        if (wrap) begin
            if (pend_full_q) begin
                active_d    = pending_q;
                pend_full_d = 1'b0;
            end else if (accept) begin
                active_d = value_in;
            end
        end else if (accept) begin
            pending_d   = value_in;
            pend_full_d = 1'b1;
        end
    end

    // Sticky flag: any illegal digit reached while its slot is showing.
    always_comb begin
        bad_d = bad_q | ((state_q == ST_SHOW) & ~bcd_is_valid(cur_digit));
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Index, buffers, segment register and error flag.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            idx_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            bad_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_in;
            bad_q       <= bad_d;
        end
    end

    assign bcd_out        = cur_digit;
    assign seg_out        = seg_q;
    assign bad_digit      = bad_q;
    assign dbg_state_o    = state_q;
    assign dbg_idx_o      = idx_q;
    assign dbg_slot_cnt_o = slot_cnt;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: 4 digits, 8-cycle slots, 2 blank cycles, decoder modelled here.
module tb_display_scan_ctrl;
    import display_pkg::*;

    localparam int ND    = 4;
    localparam int PS    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * PS;

    logic              clk;
    logic              rst_n;
    logic [4*ND-1:0]   value_in;
    logic              load_valid;
    logic              load_ready;
    logic              blank_lz;
    logic [3:0]        bcd_out;
    logic [6:0]        seg_in;
    logic [6:0]        seg_out;
    logic [ND-1:0]     digit_en_n;
    logic              frame_done;
    logic              bad_digit;
    scan_state_t       dbg_state;
    logic [1:0]        dbg_idx;
    logic [2:0]        dbg_slot_cnt;

    int                checks;
    int                errors;

    // Reference model state, indexed by cycle count since reset release.
    int                t;
    logic [15:0]       m_active;
    logic [15:0]       m_pend;
    bit                m_full;
    bit                m_bad;
    logic [6:0]        m_seg;

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .CLOCK_50       (clk),
        .RST_N          (rst_n),
        .value_in       (value_in),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .blank_lz       (blank_lz),
        .bcd_out        (bcd_out),
        .seg_in         (seg_in),
        .seg_out        (seg_out),
        .digit_en_n     (digit_en_n),
        .frame_done     (frame_done),
        .bad_digit      (bad_digit),
        .dbg_state_o    (dbg_state),
        .dbg_idx_o      (dbg_idx),
        .dbg_slot_cnt_o (dbg_slot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared BCD-to-7-segment decoder, active-low gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb seg_in = seg7(bcd_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t        = 0;
        m_active = '0;
        m_pend   = '0;
        m_full   = 1'b0;
        m_bad    = 1'b0;
        m_seg    = 7'h7F;
    endtask

    // Compare this cycle's outputs with the model, then step the model across the next edge.
    task automatic check_and_advance(input logic lz);
        int         pos;
        int         idx;
        bit         show;
        bit         supp;
        bit         fd;
        bit         acc;
        logic [3:0] dig;
        logic [3:0] en;
        pos  = t % PS;
        idx  = (t / PS) % ND;
        show = (pos >= BC);
        dig  = 4'((m_active >> (4 * idx)) & 16'hF);
        supp = lz && (idx > 0) && ((m_active >> (4 * idx)) == 16'h0);
        en   = 4'hF;
        if (show && !supp && dig <= 4'd9) en[idx] = 1'b0;
        fd   = ((t % FRAME) == FRAME - 1);

        chk("digit_en_n", 32'(digit_en_n), 32'(en));
        chk("bcd_out", 32'(bcd_out), 32'(dig));
        chk("seg_out", 32'(seg_out), 32'(m_seg));
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("load_ready", 32'(load_ready), 32'(!m_full));
        chk("bad_digit", 32'(bad_digit), 32'(m_bad));
        chk("dbg_state", 32'(dbg_state), show ? 32'(ST_SHOW) : 32'(ST_BLANK));
        chk("dbg_idx", 32'(dbg_idx), 32'(idx));
        chk("dbg_slot_cnt", 32'(dbg_slot_cnt), 32'(pos));

        acc   = load_valid && !m_full;
        m_seg = seg7(dig);
        if (show && dig > 4'd9) m_bad = 1'b1;
        if (fd) begin
            if (m_full) begin
                m_active = m_pend;
                m_full   = 1'b0;
            end else if (acc) begin
                m_active = value_in;
            end
        end else if (acc) begin
            m_pend = value_in;
            m_full = 1'b1;
        end
        t++;
    endtask

    task automatic tick(input logic v, input logic [15:0] val, input logic lz);
        @(negedge clk);
        load_valid = v;
        value_in   = val;
        blank_lz   = lz;
        #1;
        check_and_advance(lz);
    endtask

    initial begin
        logic        rv;
        logic [15:0] rval;
        logic        rlz;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        value_in   = '0;
        blank_lz   = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg_out", 32'(seg_out), 32'h7F);
        chk("rst_digit_en_n", 32'(digit_en_n), 32'hF);
        chk("rst_load_ready", 32'(load_ready), 32'h1);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_bad_digit", 32'(bad_digit), 32'h0);
        chk("rst_bcd_out", 32'(bcd_out), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();

        // Idle scanning of zeros.
        repeat (70) tick(1'b0, 16'h0000, 1'b0);

        // Mid-frame load; a second offer while not ready must be ignored.
        tick(1'b1, 16'h1234, 1'b0);
        repeat (5) tick(1'b1, 16'h5678, 1'b0);
        chk("ready_low_after_load", 32'(load_ready), 32'h0);
        repeat (60) tick(1'b0, 16'h0000, 1'b0);

        // Load on the exact wrap cycle with pending empty: bypass to the frame starting now.
        while ((t % FRAME) != FRAME - 1) tick(1'b0, 16'h0000, 1'b0);
        tick(1'b1, 16'h9876, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        chk("bypass_bcd_digit0", 32'(bcd_out), 32'h6);
        chk("bypass_ready", 32'(load_ready), 32'h1);
        repeat (40) tick(1'b0, 16'h0000, 1'b0);

        // Leading-zero suppression.
        tick(1'b1, 16'h0050, 1'b1);
        repeat (70) tick(1'b0, 16'h0000, 1'b1);
        tick(1'b1, 16'h0000, 1'b1);
        repeat (70) tick(1'b0, 16'h0000, 1'b1);

        // Illegal digit, then a legal value: the error flag stays set.
        tick(1'b1, 16'h00A3, 1'b0);
        repeat (70) tick(1'b0, 16'h0000, 1'b0);
        chk("bad_set", 32'(bad_digit), 32'h1);
        tick(1'b1, 16'h0003, 1'b0);
        repeat (70) tick(1'b0, 16'h0000, 1'b0);
        chk("bad_sticky", 32'(bad_digit), 32'h1);

        // Randomized traffic.
        rlz = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 5) == 0);
            for (int d = 0; d < 4; d++) begin
                rval[d*4 +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                             : 4'($urandom_range(0, 9));
            end
            if ((n % 50) == 0) rlz = 1'($urandom_range(0, 1));
            tick(rv, rval, rlz);
        end

        // Asynchronous reset in the middle of a SHOW phase with a pending value.
        for (int k = 0; k < 200 && !(m_full && (t % PS) == 4); k++) tick(1'b1, 16'h4321, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_ready_low", 32'(load_ready), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_digit_en_n", 32'(digit_en_n), 32'hF);
        chk("midrst_seg_out", 32'(seg_out), 32'h7F);
        chk("midrst_load_ready", 32'(load_ready), 32'h1);
        chk("midrst_frame_done", 32'(frame_done), 32'h0);
        chk("midrst_bad_digit", 32'(bad_digit), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        repeat (40) tick(1'b0, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
